// File: rtl/tick_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tick_debouncer_pkg
// Purpose  : Shared state encoding and constants for the tick debouncer.
// Revision : 1.0 - initial release
// ============================================================================
package tick_debouncer_pkg;

    // Encodings are fixed so bit 1 reads as the accepted level in the
    // stable states and as the level being left in the wait states.
    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b11,
        WAIT_LO   = 2'b10
    } db_state_e;

    localparam int SYNC_STAGES = 2;

    function automatic logic is_wait_state(input db_state_e st);
        return (st == WAIT_HI) || (st == WAIT_LO);
    endfunction

    function automatic db_state_e stable_state(input logic level);
        return level ? STABLE_HI : STABLE_LO;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer for a single asynchronous bit, with a
//            configurable reset value and synchronous active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff
    import tick_debouncer_pkg::*;
#(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/tick_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tick_debouncer
// Purpose  : Tick-paced debouncer producing a clean level and rise/fall
//            pulses. Define TICK_DEBOUNCER_SYNC_EN to add a 2-flop input
//            synchronizer for truly asynchronous inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tick_debouncer
    import tick_debouncer_pkg::*;
#(
    parameter int STABLE_TICKS = 4,
    parameter int CNT_BITS     = 3,
    parameter bit RESET_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic tick,
    input  logic btn_raw,
    output logic btn_db,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_BITS-1:0] c_cnt_last    = CNT_BITS'(STABLE_TICKS - 1);
    localparam logic [CNT_BITS-1:0] c_cnt_one     = CNT_BITS'(1);
    localparam db_state_e           c_reset_state = RESET_LEVEL ? STABLE_HI : STABLE_LO;

    logic samp;

`ifdef TICK_DEBOUNCER_SYNC_EN
    sync_2ff #(
        .RESET_VAL (RESET_LEVEL)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (btn_raw),
        .q       (samp)
    );
`else
    assign samp = btn_raw;
`endif

    db_state_e           state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q,   cnt_d;
    logic                btn_db_q, btn_db_d;
    logic                rise_q,   rise_d;
    logic                fall_q,   fall_d;
    logic                busy_q,   busy_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= c_reset_state;
            cnt_q    <= '0;
            btn_db_q <= RESET_LEVEL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            btn_db_q <= btn_db_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        btn_db_d = btn_db_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;

        if (enable) begin
            case (state_q)
                STABLE_LO: begin
                    if (samp) begin
                        state_d = WAIT_HI;
                        cnt_d   = '0;
                    end
                end
                WAIT_HI: begin
                    // Falling back to the old level wins over a coincident tick.
                    if (!samp) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                    end else if (tick) begin
                        if (cnt_q == c_cnt_last) begin
                            state_d  = STABLE_HI;
                            cnt_d    = '0;
                            btn_db_d = 1'b1;
                            rise_d   = 1'b1;
                        end else begin
                            cnt_d = cnt_q + c_cnt_one;
                        end
                    end
                end
                STABLE_HI: begin
                    if (!samp) begin
                        state_d = WAIT_LO;
                        cnt_d   = '0;
                    end
                end
                WAIT_LO: begin
                    if (samp) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                    end else if (tick) begin
                        if (cnt_q == c_cnt_last) begin
                            state_d  = STABLE_LO;
                            cnt_d    = '0;
                            btn_db_d = 1'b0;
                            fall_d   = 1'b1;
                        end else begin
                            cnt_d = cnt_q + c_cnt_one;
                        end
                    end
                end
                default: begin
                    state_d  = stable_state(btn_db_q);
                    cnt_d    = '0;
                end
            endcase
        end

        busy_d = is_wait_state(state_d);
    end

    assign btn_db = btn_db_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_tick_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_debouncer
// Purpose  : Scoreboard bench for tick_debouncer (STABLE_TICKS=4, tick every
//            10 cycles); adapts input latency to TICK_DEBOUNCER_SYNC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_debouncer;

`ifdef TICK_DEBOUNCER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int N_TICKS = 4;

    logic clk, reset_n, enable, tick, btn_raw;
    logic btn_db, rise, fall, busy;

    tick_debouncer #(
        .STABLE_TICKS (N_TICKS),
        .CNT_BITS     (3),
        .RESET_LEVEL  (1'b0)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .tick    (tick),
        .btn_raw (btn_raw),
        .btn_db  (btn_db),
        .rise    (rise),
        .fall    (fall),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic db;
        logic rise;
        logic fall;
        logic busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   tphase   = 0;
    int   rise_cnt = 0;
    int   fall_cnt = 0;
    logic last_tk  = 1'b0;
    logic cur_rstn = 1'b0;
    logic cur_en   = 1'b1;
    logic cur_btn  = 1'b0;

    // reference model state
    logic m_lvl = 1'b0, m_pend = 1'b0, m_s1 = 1'b0, m_s2 = 1'b0;
    int   m_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge(input logic tk);
        exp_t e;
        logic s;
        e = '0;
        if (!cur_rstn) begin
            m_lvl = 1'b0; m_pend = 1'b0; m_cnt = 0; m_s1 = 1'b0; m_s2 = 1'b0;
        end else begin
            s    = (LAT == 2) ? m_s2 : cur_btn;
            m_s2 = m_s1;
            m_s1 = cur_btn;
            if (cur_en) begin
                if (!m_pend) begin
                    if (s != m_lvl) begin m_pend = 1'b1; m_cnt = 0; end
                end else if (s == m_lvl) begin
                    m_pend = 1'b0; m_cnt = 0;
                end else if (tk) begin
                    if (m_cnt == N_TICKS - 1) begin
                        m_lvl = s; m_pend = 1'b0; m_cnt = 0;
                        e.rise = s; e.fall = ~s;
                    end else begin
                        m_cnt++;
                    end
                end
            end
            e.db   = m_lvl;
            e.busy = m_pend;
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic tk);
        exp_t e;
        reset_n = cur_rstn;
        enable  = cur_en;
        btn_raw = cur_btn;
        tick    = tk;
        last_tk = tk;
        model_edge(tk);
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() == 0) begin
            check_val("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_val("sb_btn_db", btn_db, e.db);
            check_val("sb_rise",   rise,   e.rise);
            check_val("sb_fall",   fall,   e.fall);
            check_val("sb_busy",   busy,   e.busy);
        end
        if (rise === 1'b1) rise_cnt++;
        if (fall === 1'b1) fall_cnt++;
    endtask

    // periodic tick, one every 10 cycles
    task automatic tstep();
        logic tk;
        tk     = (tphase == 9);
        tphase = (tphase == 9) ? 0 : tphase + 1;
        step(tk);
    endtask

    task automatic wait_busy(input string tag, output int n);
        bit found;
        found = 1'b0;
        n     = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            tstep();
            n++;
            if (busy === 1'b1) found = 1'b1;
        end
        if (!found) check_val({tag, "_busy_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_pulse(input string tag, input bit want_rise, output int ticks);
        bit found;
        found = 1'b0;
        ticks = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            tstep();
            if (last_tk) ticks++;
            if ((want_rise ? rise : fall) === 1'b1) found = 1'b1;
        end
        if (!found) check_val({tag, "_pulse_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int n, t, r0, f0;
        reset_n = 1'b0; enable = 1'b1; tick = 1'b0; btn_raw = 1'b0;

        // reset wins over enable, tick and a high input
        cur_rstn = 1'b0; cur_en = 1'b1; cur_btn = 1'b1;
        step(1'b1);
        check_val("rst_btn_db", btn_db, 0);
        check_val("rst_busy",   busy,   0);
        step(1'b1);
        step(1'b1);
        cur_rstn = 1'b1; cur_btn = 1'b0;
        repeat (LAT + 3) tstep();

        // clean press
        cur_btn = 1'b1;
        wait_busy("press", n);
        check_val("press_busy_edge", n, LAT + 1);
        wait_pulse("press", 1'b1, t);
        check_val("press_ticks",    t,      N_TICKS);
        check_val("press_db",       btn_db, 1);
        check_val("press_busy_clr", busy,   0);
        tstep();
        check_val("press_rise_1cyc", rise, 0);

        // clean release
        cur_btn = 1'b0;
        wait_busy("release", n);
        check_val("release_busy_edge", n, LAT + 1);
        wait_pulse("release", 1'b0, t);
        check_val("release_ticks", t,      N_TICKS);
        check_val("release_db",    btn_db, 0);

        // abort coincident with the terminal tick
        r0 = rise_cnt;
        cur_btn = 1'b1;
        wait_busy("abort", n);
        repeat (N_TICKS - 1) step(1'b1);
        cur_btn = 1'b0;
        repeat (LAT) step(1'b0);
        step(1'b1);
        check_val("abort_busy",  busy,          0);
        check_val("abort_db",    btn_db,        0);
        check_val("abort_rises", rise_cnt - r0, 0);
        repeat (5) tstep();

        // bouncing input, then settled high
        r0 = rise_cnt;
        for (int i = 0; i < 30; i++) begin
            cur_btn = ((i / 3) % 2 == 0);
            tstep();
        end
        check_val("bounce_rises", rise_cnt - r0, 0);
        check_val("bounce_db",    btn_db,        0);
        cur_btn = 1'b1;
        wait_busy("bounce", n);
        check_val("bounce_busy_edge", n, LAT + 1);
        wait_pulse("bounce", 1'b1, t);
        check_val("bounce_ticks", t, N_TICKS);
        repeat (30) tstep();
        check_val("bounce_one_rise", rise_cnt - r0, 1);

        // second release
        cur_btn = 1'b0;
        wait_busy("release2", n);
        wait_pulse("release2", 1'b0, t);
        check_val("release2_ticks", t, N_TICKS);

        // enable freeze with one tick already counted
        cur_btn = 1'b1;
        wait_busy("freeze", n);
        for (int k = 0; k < 20; k++) begin
            tstep();
            if (last_tk) break;
        end
        r0 = rise_cnt;
        cur_en = 1'b0;
        repeat (50) tstep();
        check_val("freeze_rises", rise_cnt - r0, 0);
        check_val("freeze_busy",  busy,          1);
        cur_en = 1'b1;
        wait_pulse("freeze", 1'b1, t);
        check_val("freeze_ticks", t, N_TICKS - 1);

        // reset in WAIT_LO drops the partial qualification silently
        f0 = fall_cnt;
        cur_btn = 1'b0;
        wait_busy("rstwait", n);
        cur_rstn = 1'b0;
        step(1'b0);
        check_val("rstwait_busy", busy,   0);
        check_val("rstwait_db",   btn_db, 0);
        cur_rstn = 1'b1;
        repeat (60) tstep();
        check_val("rstwait_falls", fall_cnt - f0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
